// File: rtl/completion_queue_mp.sv
// Multi-port completion queue: gathers results from NUM_SRC units and broadcasts
// them one per cycle on the CDB. Optional same-edge bypass when CQ_BYPASS_EN is defined.
module completion_queue_mp #(
  parameter int              NUM_SRC     = 4,
  parameter int              DEPTH       = 16,
  parameter int              TAG_W       = 4,
  parameter int              DATA_W      = 32,
  parameter logic [TAG_W-1:0] INVALID_TAG = '0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       FLUSH,
  input  logic [NUM_SRC*TAG_W-1:0]   TAG_IN,
  input  logic [NUM_SRC*DATA_W-1:0]  DATA_IN,
  output logic                       IN_READY,
  output logic [TAG_W-1:0]           CDB_TAG,
  output logic [DATA_W-1:0]          CDB_DATA,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       OVERFLOW
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  ptr_t              head_q, tail_q;
  cnt_t              count_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic              overflow_q;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC-1:0] wr_en;
  ptr_t               wr_addr [NUM_SRC];
  cnt_t               free_slots;
  cnt_t               accepted;
  cnt_t               count_next;
  logic               pop;
  logic               drop;
  logic               do_bypass;

`ifdef CQ_BYPASS_EN
  logic               bypass_taken;
  logic [TAG_W-1:0]   byp_tag;
  logic [DATA_W-1:0]  byp_data;

  assign do_bypass = (count_q == '0) && (|src_valid);
`else
  assign do_bypass = 1'b0;
`endif

  assign free_slots = cnt_t'(DEPTH) - count_q;
  assign pop        = (count_q != '0);

  // Pack valid sources into consecutive tail slots, lowest index first; anything
  // beyond the free space (measured before this cycle's pop) is dropped.
  // NOTE: blocking assignments here model a running counter inside one
  // combinational evaluation; every output gets a default first so no latch forms.
  always_comb begin
    accepted = '0;
    drop     = 1'b0;
    wr_en    = '0;
`ifdef CQ_BYPASS_EN
    bypass_taken = 1'b0;
    byp_tag      = INVALID_TAG;
    byp_data     = '0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      src_valid[i] = (TAG_IN[i*TAG_W +: TAG_W] != INVALID_TAG);
      wr_addr[i]   = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i]) begin
`ifdef CQ_BYPASS_EN
        if (do_bypass && !bypass_taken) begin
          bypass_taken = 1'b1;
          byp_tag      = TAG_IN[i*TAG_W +: TAG_W];
          byp_data     = DATA_IN[i*DATA_W +: DATA_W];
        end else
`endif
        if (accepted < free_slots) begin
          wr_en[i]   = 1'b1;
          wr_addr[i] = tail_q + ptr_t'(accepted);
          accepted   = accepted + cnt_t'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
    count_next = count_q + accepted - cnt_t'(pop);
  end

  // NOTE: the storage array carries no reset; head/tail/count define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (!FLUSH) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (wr_en[i]) begin
          tag_mem[wr_addr[i]]  <= TAG_IN[i*TAG_W +: TAG_W];
          data_mem[wr_addr[i]] <= DATA_IN[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cdb_tag_q  <= INVALID_TAG;
      cdb_data_q <= '0;
      overflow_q <= 1'b0;
    end else if (FLUSH) begin
      // Mispredict recovery: discard everything, keep the sticky overflow.
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      cdb_tag_q <= INVALID_TAG;
    end else begin
      tail_q  <= tail_q + ptr_t'(accepted);
      count_q <= count_next;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (pop) begin
        cdb_tag_q  <= tag_mem[head_q];
        cdb_data_q <= data_mem[head_q];
        head_q     <= head_q + ptr_t'(1);
`ifdef CQ_BYPASS_EN
      end else if (do_bypass) begin
        cdb_tag_q  <= byp_tag;
        cdb_data_q <= byp_data;
`endif
      end else begin
        cdb_tag_q <= INVALID_TAG;
      end
    end
  end

  assign IN_READY = (free_slots >= cnt_t'(NUM_SRC));
  assign CDB_TAG  = cdb_tag_q;
  assign CDB_DATA = cdb_data_q;
  assign COUNT    = count_q;
  assign OVERFLOW = overflow_q;

endmodule
